// File: rtl/uart_frame_parser_pkg.sv
// rtl/uart_frame_parser_pkg.sv - shared types and constants for the UART frame parser
package uart2spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_GET_CMD,
    ST_GET_LEN,
    ST_GET_PAY,
    ST_GET_CHK,
    ST_STREAM
  } state_e;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CHK  = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEF_HDR0 = 8'h55;
  localparam logic [7:0] DEF_HDR1 = 8'hA5;

  // Keeps a one-entry buffer addressable with a 1-bit pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_frame_parser_if.sv
// rtl/uart_frame_parser_if.sv - byte-in / command-and-payload-out bundle of the frame parser
interface uart_frame_parser_if;
  logic [7:0] Rx_Data;
  logic       Rx_Done;
  logic [7:0] Cmd;
  logic       Cmd_Valid;
  logic [7:0] Pay_Data;
  logic       Pay_Valid;
  logic       Pay_Ready;
  logic       Frame_Done;
  logic       Frame_Err;
  logic [1:0] Err_Code;

  modport master (
    input  Rx_Data, Rx_Done, Pay_Ready,
    output Cmd, Cmd_Valid, Pay_Data, Pay_Valid, Frame_Done, Frame_Err, Err_Code
  );

  modport slave (
    output Rx_Data, Rx_Done, Pay_Ready,
    input  Cmd, Cmd_Valid, Pay_Data, Pay_Valid, Frame_Done, Frame_Err, Err_Code
  );
endinterface

// File: rtl/uart_frame_buf.sv
// rtl/uart_frame_buf.sv - payload holding buffer, one write port and one async read port
module uart_frame_buf
  import uart2spi_pkg::*;
#(
  parameter  int MAX_LEN = 16,
  localparam int PTR_W   = ptr_width(MAX_LEN)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_addr,
  input  logic [7:0]       wr_data,
  input  logic [PTR_W-1:0] rd_addr,
  output logic [7:0]       rd_data
);

  logic [7:0] mem_q [MAX_LEN];
  logic [7:0] mem_d [MAX_LEN];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - extracts checksummed command frames from a UART byte stream
module uart_frame_parser
  import uart2spi_pkg::*;
#(
  parameter logic [7:0] HDR0    = DEF_HDR0,
  parameter logic [7:0] HDR1    = DEF_HDR1,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 2_000_000
) (
  input logic                 Clk,
  input logic                 Reset,
  uart_frame_parser_if.master bus
);

  localparam int               PTR_W     = ptr_width(MAX_LEN);
  localparam int               TMR_W     = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_e           state_q,      state_d;
  logic [7:0]       cmd_pend_q,   cmd_pend_d;
  logic [7:0]       cmd_q,        cmd_d;
  logic [7:0]       len_q,        len_d;
  logic [7:0]       sum_q,        sum_d;
  logic [7:0]       cnt_q,        cnt_d;
  logic [7:0]       rd_ptr_q,     rd_ptr_d;
  logic [TMR_W-1:0] timer_q,      timer_d;
  logic             cmd_valid_q,  cmd_valid_d;
  logic             pay_valid_q,  pay_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_err_q,  frame_err_d;
  logic [1:0]       err_code_q,   err_code_d;

  logic       buf_we;
  logic [7:0] buf_rd_data;
  logic       rx;
  logic [7:0] rx_byte;
  logic       in_frame;

  assign rx       = bus.Rx_Done;
  assign rx_byte  = bus.Rx_Data;
  assign in_frame = (state_q == ST_SYNC)    || (state_q == ST_GET_CMD) ||
                    (state_q == ST_GET_LEN) || (state_q == ST_GET_PAY) ||
                    (state_q == ST_GET_CHK);

  uart_frame_buf #(
    .MAX_LEN (MAX_LEN)
  ) u_buf (
    .clk     (Clk),
    .wr_en   (buf_we),
    .wr_addr (cnt_q[PTR_W-1:0]),
    .wr_data (rx_byte),
    .rd_addr (rd_ptr_q[PTR_W-1:0]),
    .rd_data (buf_rd_data)
  );

  always_comb begin
    state_d      = state_q;
    cmd_pend_d   = cmd_pend_q;
    cmd_d        = cmd_q;
    len_d        = len_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    rd_ptr_d     = rd_ptr_q;
    timer_d      = timer_q;
    pay_valid_d  = pay_valid_q;
    err_code_d   = err_code_q;
    cmd_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    buf_we       = 1'b0;

    // Inter-byte watchdog; a byte arriving in the expiry cycle keeps the frame alive.
    if (in_frame) begin
      if (rx) begin
        timer_d = '0;
      end else if (timer_q == TMR_LAST) begin
        timer_d     = '0;
        state_d     = ST_IDLE;
        frame_err_d = 1'b1;
        err_code_d  = ERR_TMO;
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (rx && rx_byte == HDR0) begin
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (rx) begin
          if (rx_byte == HDR1) begin
            state_d = ST_GET_CMD;
          end else if (rx_byte != HDR0) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_GET_CMD: begin
        if (rx) begin
          cmd_pend_d = rx_byte;
          sum_d      = rx_byte;
          state_d    = ST_GET_LEN;
        end
      end
      ST_GET_LEN: begin
        if (rx) begin
          len_d = rx_byte;
          sum_d = sum_q + rx_byte;
          cnt_d = '0;
          if (rx_byte > MAX_LEN_B) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_LEN;
          end else if (rx_byte == 8'd0) begin
            state_d = ST_GET_CHK;
          end else begin
            state_d = ST_GET_PAY;
          end
        end
      end
      ST_GET_PAY: begin
        if (rx) begin
          buf_we = 1'b1;
          sum_d  = sum_q + rx_byte;
          cnt_d  = cnt_q + 8'd1;
          if (cnt_q + 8'd1 == len_q) begin
            state_d = ST_GET_CHK;
          end
        end
      end
      ST_GET_CHK: begin
        if (rx) begin
          if (rx_byte != sum_q) begin
            state_d     = ST_IDLE;
            frame_err_d = 1'b1;
            err_code_d  = ERR_CHK;
          end else begin
            cmd_d       = cmd_pend_q;
            cmd_valid_d = 1'b1;
            if (len_q == 8'd0) begin
              state_d      = ST_IDLE;
              frame_done_d = 1'b1;
            end else begin
              state_d     = ST_STREAM;
              pay_valid_d = 1'b1;
              rd_ptr_d    = '0;
            end
          end
        end
      end
      ST_STREAM: begin
        // The parser cannot take a new frame while draining; the byte is lost.
        if (rx) begin
          frame_err_d = 1'b1;
          err_code_d  = ERR_TMO;
        end
        if (pay_valid_q && bus.Pay_Ready) begin
          if (rd_ptr_q + 8'd1 == len_q) begin
            pay_valid_d  = 1'b0;
            frame_done_d = 1'b1;
            state_d      = ST_IDLE;
          end else begin
            rd_ptr_d = rd_ptr_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      cmd_pend_q   <= '0;
      cmd_q        <= '0;
      len_q        <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      rd_ptr_q     <= '0;
      timer_q      <= '0;
      cmd_valid_q  <= 1'b0;
      pay_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cmd_pend_q   <= cmd_pend_d;
      cmd_q        <= cmd_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      rd_ptr_q     <= rd_ptr_d;
      timer_q      <= timer_d;
      cmd_valid_q  <= cmd_valid_d;
      pay_valid_q  <= pay_valid_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.Cmd        = cmd_q;
  assign bus.Cmd_Valid  = cmd_valid_q;
  assign bus.Pay_Valid  = pay_valid_q;
  assign bus.Pay_Data   = pay_valid_q ? buf_rd_data : 8'h00;
  assign bus.Frame_Done = frame_done_q;
  assign bus.Frame_Err  = frame_err_q;
  assign bus.Err_Code   = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - directed self-checking bench for uart_frame_parser
module tb_uart_frame_parser;

  localparam int         TIMEOUT = 100;
  localparam logic [7:0] HDR0    = 8'h55;
  localparam logic [7:0] HDR1    = 8'hA5;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [7:0] pay [16];

  uart_frame_parser_if bus ();

  uart_frame_parser #(
    .HDR0    (HDR0),
    .HDR1    (HDR1),
    .MAX_LEN (16),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.Rx_Data = b;
    bus.Rx_Done = 1'b1;
    tick();
    bus.Rx_Done = 1'b0;
    bus.Rx_Data = 8'h00;
  endtask

  // Checksum covers CMD, LEN and every payload byte; chk_flip corrupts it on purpose.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input logic [7:0] chk_flip);
    logic [7:0] sum;
    sum = cmd + len;
    send(HDR0);
    send(HDR1);
    send(cmd);
    send(len);
    for (int i = 0; i < int'(len); i++) begin
      send(pay[i]);
      sum = sum + pay[i];
    end
    send(sum ^ chk_flip);
  endtask

  function automatic logic [21:0] outs();
    return {bus.Cmd, bus.Cmd_Valid, bus.Pay_Data, bus.Pay_Valid,
            bus.Frame_Done, bus.Frame_Err, bus.Err_Code};
  endfunction

  initial begin
    int  n;
    logic stable;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.Rx_Data   = 8'h00;
    bus.Rx_Done   = 1'b0;
    bus.Pay_Ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_outputs", 32'(outs()), 32'd0);

    // Good two-byte frame, checksum 10+02+AA+BB = 77
    pay[0] = 8'hAA;
    pay[1] = 8'hBB;
    send_frame(8'h10, 8'd2, 8'h00);
    chk("t1_cmd_valid", 32'(bus.Cmd_Valid), 32'd1);
    chk("t1_cmd", 32'(bus.Cmd), 32'h10);
    chk("t1_pay_valid", 32'(bus.Pay_Valid), 32'd1);
    chk("t1_pay0", 32'(bus.Pay_Data), 32'hAA);
    chk("t1_no_err", 32'(bus.Frame_Err), 32'd0);
    tick();
    chk("t1_cmd_valid_pulse", 32'(bus.Cmd_Valid), 32'd0);
    chk("t1_pay1", 32'(bus.Pay_Data), 32'hBB);
    tick();
    chk("t1_pay_valid_drop", 32'(bus.Pay_Valid), 32'd0);
    chk("t1_frame_done", 32'(bus.Frame_Done), 32'd1);
    chk("t1_err_code", 32'(bus.Err_Code), 32'd0);
    tick();
    chk("t1_frame_done_pulse", 32'(bus.Frame_Done), 32'd0);

    // Same frame with CHK=76
    send_frame(8'h10, 8'd2, 8'h01);
    chk("t2_frame_err", 32'(bus.Frame_Err), 32'd1);
    chk("t2_err_code", 32'(bus.Err_Code), 32'd2);
    chk("t2_no_cmd_valid", 32'(bus.Cmd_Valid), 32'd0);
    chk("t2_no_pay_valid", 32'(bus.Pay_Valid), 32'd0);
    tick();
    chk("t2_err_pulse", {30'd0, bus.Frame_Err, bus.Pay_Valid}, 32'd0);
    send_frame(8'h10, 8'd2, 8'h00);
    chk("t2_recover_cmd_valid", 32'(bus.Cmd_Valid), 32'd1);
    chk("t2_recover_pay0", 32'(bus.Pay_Data), 32'hAA);
    tick();
    tick();
    chk("t2_recover_done", 32'(bus.Frame_Done), 32'd1);
    chk("t2_err_code_held", 32'(bus.Err_Code), 32'd2);

    // Resync on repeated HDR0, zero-length frame
    send(8'h55);
    send(8'h55);
    send(8'hA5);
    send(8'h20);
    send(8'h00);
    send(8'h20);
    chk("t3_cmd_valid_done", {30'd0, bus.Cmd_Valid, bus.Frame_Done}, 32'd3);
    chk("t3_cmd", 32'(bus.Cmd), 32'h20);
    chk("t3_no_pay_valid", 32'(bus.Pay_Valid), 32'd0);
    tick();
    chk("t3_pulses_clear", {30'd0, bus.Cmd_Valid, bus.Frame_Done}, 32'd0);

    // LEN=17 exceeds buffer
    send(8'h55);
    send(8'hA5);
    send(8'h01);
    send(8'h11);
    chk("t4_frame_err", 32'(bus.Frame_Err), 32'd1);
    chk("t4_err_code", 32'(bus.Err_Code), 32'd1);

    // Inter-byte timeout while waiting for LEN
    send(8'h55);
    send(8'hA5);
    send(8'h01);
    n = 0;
    while (bus.Frame_Err !== 1'b1 && n < 4 * TIMEOUT) begin
      tick();
      n++;
    end
    chk("t5_timeout_cycles", 32'(n), 32'(TIMEOUT));
    chk("t5_err_code", 32'(bus.Err_Code), 32'd3);
    send(8'h55);
    send(8'hA5);
    send(8'h01);
    send(8'h00);
    send(8'h01);
    chk("t5_accept", {22'd0, bus.Cmd, bus.Cmd_Valid, bus.Frame_Done}, {22'd0, 8'h01, 1'b1, 1'b1});

    // Backpressure, byte dropped during STREAM
    bus.Pay_Ready = 1'b0;
    send_frame(8'h10, 8'd2, 8'h00);
    stable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (bus.Pay_Data !== 8'hAA || bus.Pay_Valid !== 1'b1) stable = 1'b0;
      tick();
    end
    chk("t6_stall_stable", 32'(stable), 32'd1);
    send(8'h33);
    chk("t6_stream_rx_err", 32'(bus.Frame_Err), 32'd1);
    chk("t6_stream_rx_code", 32'(bus.Err_Code), 32'd3);
    chk("t6_still_aa", {23'd0, bus.Pay_Valid, bus.Pay_Data}, {23'd0, 1'b1, 8'hAA});
    bus.Pay_Ready = 1'b1;
    tick();
    chk("t6_pay1", 32'(bus.Pay_Data), 32'hBB);
    tick();
    chk("t6_done", {30'd0, bus.Pay_Valid, bus.Frame_Done}, 32'd1);

    // Reset in the middle of GET_PAY
    send(8'h55);
    send(8'hA5);
    send(8'h10);
    send(8'h02);
    send(8'hAA);
    rst = 1'b1;
    tick();
    chk("t6_reset_outputs", 32'(outs()), 32'd0);
    rst = 1'b0;
    send(8'hBB);
    send(8'h77);
    tick();
    chk("t6_after_reset_idle", {30'd0, bus.Cmd_Valid, bus.Frame_Err}, 32'd0);

    // Full-depth payload
    for (int i = 0; i < 16; i++) pay[i] = 8'(i * 3 + 1);
    send_frame(8'h30, 8'd16, 8'h00);
    chk("t7_cmd_valid", 32'(bus.Cmd_Valid), 32'd1);
    for (int i = 0; i < 16; i++) begin
      chk("t7_pay", {23'd0, bus.Pay_Valid, bus.Pay_Data}, {23'd0, 1'b1, pay[i]});
      tick();
    end
    chk("t7_done", {30'd0, bus.Pay_Valid, bus.Frame_Done}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
